// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive packet controller:
//   - state_t          : controller state encoding (IDLE, LEN, PAYLOAD, CHK, DRAIN)
//   - SYNC_BYTE_DEFAULT: default frame start marker
//   - buf_addr_width() : address width for a payload buffer of a given depth
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // A depth-1 buffer still needs a 1-bit address so port widths stay legal.
    function automatic int buf_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// -----------------------------------------------------------------------------
// uart_pkt_buf
// Payload buffer: DEPTH x 8 memory, one write port, one registered read port.
// Written as a plain array so it maps onto block/distributed RAM.
// Ports:
//   clk      in   system clock
//   wr_en    in   write strobe
//   wr_addr  in   write address  [AW-1:0]
//   wr_data  in   write data     [7:0]
//   rd_addr  in   read address   [AW-1:0], sampled every cycle
//   rd_data  out  mem[rd_addr] from the previous clock edge
// -----------------------------------------------------------------------------
module uart_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_pkt_ctrl
// Frames the UART receiver byte stream into packets
//     SYNC, LEN, LEN payload bytes, CHK
// buffers the payload, validates length and checksum (mod-256 sum of LEN and
// payload) and releases good packets on a valid/ready byte stream with m_last.
//
// Optional feature macro: RX_TIMEOUT_EN
//   defined   : inter-byte idle timer inside a frame; after TIMEOUT_CYC idle
//               cycles the frame is dropped with a to_err pulse.
//   undefined : no timer, to_err tied low, frames wait forever.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   controller enable; low aborts any frame/drain
//   rx_en      out  receiver enable (registered copy of en)
//   rx_done    in   one-cycle strobe, rx_data valid
//   rx_data    in   received byte
//   m_valid    out  payload byte valid
//   m_data     out  payload byte
//   m_last     out  final payload byte of the packet
//   m_ready    in   consumer ready
//   len_err    out  pulse: LEN of 0 or above MAX_LEN
//   chk_err    out  pulse: checksum mismatch
//   ovr_err    out  pulse: byte received while draining (dropped)
//   to_err     out  pulse: inter-byte timeout
//   pkt_count  out  good packets fully drained (wrapping)
// -----------------------------------------------------------------------------
module uart_rx_pkt_ctrl
    import uart_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rx_en,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    input  logic        m_ready,
    output logic        len_err,
    output logic        chk_err,
    output logic        ovr_err,
    output logic        to_err,
    output logic [15:0] pkt_count
);

    localparam int         AW        = buf_addr_width(MAX_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t      state_reg, state_next;
    logic [7:0]  len_reg, len_next;
    logic [7:0]  sum_reg, sum_next;
    logic [7:0]  idx_reg, idx_next;
    logic [7:0]  rd_reg, rd_next;
    logic [15:0] pkt_count_reg, pkt_count_next;
    logic        rx_en_reg;
    logic        len_err_reg, len_err_next;
    logic        chk_err_reg, chk_err_next;
    logic        ovr_err_reg, ovr_err_next;

    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic [AW-1:0] buf_rd_addr;
    logic [7:0]    buf_rd_data;

    logic draining;
    logic last_beat;

    assign draining  = (state_reg == ST_DRAIN);
    assign last_beat = (rd_reg == (len_reg - 8'd1));

`ifdef RX_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    logic [31:0] idle_cnt_reg;
    logic        in_frame;
    logic        timeout_hit;
    logic        to_err_reg, to_err_next;

    assign in_frame = (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD) ||
                      (state_reg == ST_CHK);
    // The counter holds the number of idle cycles already seen, so the
    // cycle on which it equals TIMEOUT_CYC-1 without a byte is the
    // TIMEOUT_CYC-th idle cycle.
    assign timeout_hit = in_frame && !rx_done && (idle_cnt_reg == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_reg <= 32'd0;
        end else if (!in_frame || rx_done) begin
            idle_cnt_reg <= 32'd0;
        end else begin
            idle_cnt_reg <= idle_cnt_reg + 32'd1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state / datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        sum_next       = sum_reg;
        idx_next       = idx_reg;
        rd_next        = rd_reg;
        pkt_count_next = pkt_count_reg;
        len_err_next   = 1'b0;
        chk_err_next   = 1'b0;
        ovr_err_next   = 1'b0;
        buf_wr_en      = 1'b0;
`ifdef RX_TIMEOUT_EN
        to_err_next    = 1'b0;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (rx_done && (rx_data == SYNC_BYTE)) begin
                    state_next = ST_LEN;
                end
            end

            ST_LEN: begin
                if (rx_done) begin
                    if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                        len_err_next = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        len_next   = rx_data;
                        sum_next   = rx_data;
                        idx_next   = 8'd0;
                        state_next = ST_PAYLOAD;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (rx_done) begin
                    buf_wr_en = 1'b1;
                    sum_next  = sum_reg + rx_data;
                    idx_next  = idx_reg + 8'd1;
                    if (idx_reg == (len_reg - 8'd1)) begin
                        state_next = ST_CHK;
                    end
                end
            end

            ST_CHK: begin
                if (rx_done) begin
                    if (rx_data == sum_reg) begin
                        rd_next    = 8'd0;
                        state_next = ST_DRAIN;
                    end else begin
                        chk_err_next = 1'b1;
                        state_next   = ST_IDLE;
                    end
                end
            end

            ST_DRAIN: begin
                // Any byte here is dropped, including a SYNC coinciding with
                // the final handshake: no frame starts from DRAIN.
                if (rx_done) begin
                    ovr_err_next = 1'b1;
                end
                if (m_ready) begin
                    if (last_beat) begin
                        pkt_count_next = pkt_count_reg + 16'd1;
                        state_next     = ST_IDLE;
                    end else begin
                        rd_next = rd_reg + 8'd1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

`ifdef RX_TIMEOUT_EN
        if (timeout_hit) begin
            to_err_next = 1'b1;
            state_next  = ST_IDLE;
        end
`endif

        // Disable aborts silently. A last handshake already taken by the
        // consumer in this cycle is still counted as a delivered packet.
        if (!en) begin
            state_next   = ST_IDLE;
            len_err_next = 1'b0;
            chk_err_next = 1'b0;
            ovr_err_next = 1'b0;
            buf_wr_en    = 1'b0;
`ifdef RX_TIMEOUT_EN
            to_err_next  = 1'b0;
`endif
        end
    end

    // Read address follows rd_next so the registered RAM output already holds
    // buf[rd] in the cycle the controller presents it; this gives first-byte
    // valid one cycle after the CHK byte and stable data while stalled.
    assign buf_wr_addr = idx_reg[AW-1:0];
    assign buf_rd_addr = rd_next[AW-1:0];

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_addr (buf_wr_addr),
        .wr_data (rx_data),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            len_reg       <= 8'd0;
            sum_reg       <= 8'd0;
            idx_reg       <= 8'd0;
            rd_reg        <= 8'd0;
            pkt_count_reg <= 16'd0;
            rx_en_reg     <= 1'b0;
            len_err_reg   <= 1'b0;
            chk_err_reg   <= 1'b0;
            ovr_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            sum_reg       <= sum_next;
            idx_reg       <= idx_next;
            rd_reg        <= rd_next;
            pkt_count_reg <= pkt_count_next;
            rx_en_reg     <= en;
            len_err_reg   <= len_err_next;
            chk_err_reg   <= chk_err_next;
            ovr_err_reg   <= ovr_err_next;
        end
    end

`ifdef RX_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_err_reg <= 1'b0;
        end else begin
            to_err_reg <= to_err_next;
        end
    end
    assign to_err = to_err_reg;
`else
    assign to_err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rx_en     = rx_en_reg;
    assign m_valid   = draining;
    // RAM output register has no reset; gate it so m_data reads 0 outside DRAIN.
    assign m_data    = draining ? buf_rd_data : 8'h00;
    assign m_last    = draining && last_beat;
    assign len_err   = len_err_reg;
    assign chk_err   = chk_err_reg;
    assign ovr_err   = ovr_err_reg;
    assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_pkt_ctrl
// Self-checking bench for uart_rx_pkt_ctrl. Directed frames plus randomized
// packets compared against a frame-level reference model (expected payload
// queue and expected error counts built from the frame rules).
// -----------------------------------------------------------------------------
module tb_uart_rx_pkt_ctrl;

    localparam int         MAX_LEN = 16;
    localparam int         TO_CYC  = 100;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        m_ready = 1'b0;
    logic        rx_en;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        len_err;
    logic        chk_err;
    logic        ovr_err;
    logic        to_err;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    uart_rx_pkt_ctrl #(
        .MAX_LEN     (MAX_LEN),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rx_en     (rx_en),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .len_err   (len_err),
        .chk_err   (chk_err),
        .ovr_err   (ovr_err),
        .to_err    (to_err),
        .pkt_count (pkt_count)
    );

    int checks = 0;
    int errors = 0;

    // Monitor state
    logic [8:0] rx_q[$];     // {last, data} of every handshake
    int  n_len = 0, n_chk = 0, n_ovr = 0, n_to = 0, stab_viol = 0;
    bit  rand_ready = 1'b0;
    bit  prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (len_err) n_len++;
            if (chk_err) n_chk++;
            if (ovr_err) n_ovr++;
            if (to_err)  n_to++;
            if (!rst_n || !en) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                    stab_viol++;
                if (m_valid && m_ready) rx_q.push_back({m_last, m_data});
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    // Random backpressure, changed just after the active edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) m_ready = ($urandom_range(0, 99) < 50);
        end
    end

    task automatic clear_mon();
        @(posedge clk);
        #1;
        rx_q.delete();
        n_len = 0; n_chk = 0; n_ovr = 0; n_to = 0; stab_viol = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_rx(input int n, output bit ok);
        int k = 0;
        while (rx_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        ok = (rx_q.size() >= n);
        repeat (3) @(negedge clk);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({m_valid, m_data, m_last, len_err, chk_err, ovr_err, to_err, rx_en} !== 14'd0 ||
            pkt_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h l=%b errs=%b%b%b%b rx_en=%b cnt=%0d want all 0",
                     m_valid, m_data, m_last, len_err, chk_err, ovr_err, to_err, rx_en, pkt_count);
        end
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_en !== 1'b1) begin
            errors++;
            $display("FAIL rx_en_follow got %b want 1", rx_en);
        end
    endtask

    task automatic test_good_packet();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        clear_mon();
        m_ready = 1'b1;
        send_byte(SYNC, 0); send_byte(8'h03, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        send_byte(8'h69, 0);
        // now one cycle after the CHK byte was taken
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_d[i] || m_last !== (i == 2)) begin
                errors++;
                $display("FAIL good_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         i, m_valid, m_data, m_last, exp_d[i], (i == 2));
            end
            @(negedge clk);
        end
        checks++;
        if (m_valid !== 1'b0 || pkt_count !== 16'd1) begin
            errors++;
            $display("FAIL good_end got v=%b cnt=%0d want v=0 cnt=1", m_valid, pkt_count);
        end
    endtask

    task automatic test_chk_err();
        int seen_valid = 0;
        clear_mon();
        send_byte(SYNC, 0); send_byte(8'h03, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        send_byte(8'h68, 0);
        repeat (10) begin
            if (m_valid) seen_valid++;
            @(negedge clk);
        end
        checks++;
        if (n_chk !== 1 || seen_valid !== 0 || pkt_count !== 16'd1) begin
            errors++;
            $display("FAIL chk_err got pulses=%0d valid_cycles=%0d cnt=%0d want 1/0/1",
                     n_chk, seen_valid, pkt_count);
        end
    endtask

    task automatic test_len_err();
        bit ok;
        clear_mon();
        send_byte(SYNC, 0); send_byte(8'h00, 0);
        send_byte(SYNC, 0); send_byte(8'h11, 2);
        checks++;
        if (n_len !== 2 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL len_err got pulses=%0d v=%b want 2/0", n_len, m_valid);
        end
        // back in IDLE: a minimal packet goes through
        send_byte(SYNC, 0); send_byte(8'h01, 0); send_byte(8'h42, 0); send_byte(8'h43, 0);
        wait_rx(1, ok);
        checks++;
        if (!ok || rx_q.size() != 1 || rx_q[0] !== {1'b1, 8'h42}) begin
            errors++;
            $display("FAIL len_recover got n=%0d first=%h want n=1 first=142",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        clear_mon();
        m_ready = 1'b0;
        send_byte(SYNC, 0); send_byte(8'h03, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        send_byte(8'h69, 0);
        send_byte(8'h55, 0);   // arrives while draining
        for (int i = 0; i < 3; i++) begin
            repeat (5) begin
                @(negedge clk);
                checks++;
                if (m_valid !== 1'b1 || m_data !== exp_d[i] || m_last !== (i == 2)) begin
                    errors++;
                    $display("FAIL bp_hold%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             i, m_valid, m_data, m_last, exp_d[i], (i == 2));
                end
            end
            @(posedge clk); #1 m_ready = 1'b1;
            @(posedge clk); #1 m_ready = 1'b0;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rx_q.size() != 3 || n_ovr !== 1 || stab_viol !== 0 || pkt_count !== 16'd3) begin
            errors++;
            $display("FAIL bp_summary got n=%0d ovr=%0d stab=%0d cnt=%0d want 3/1/0/3",
                     rx_q.size(), n_ovr, stab_viol, pkt_count);
        end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== {(i == 2), exp_d[i]}) begin
                errors++;
                $display("FAIL bp_order%0d got %h want %h", i, rx_q[i], {(i == 2), exp_d[i]});
            end
        end
    endtask

    task automatic test_random();
        logic [8:0]  exp_q[$];
        logic [15:0] base;
        int          e_len = 0, e_chk = 0, e_good = 0;
        bit          ok;
        clear_mon();
        base = pkt_count;
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int kind;
            logic [7:0] s, b, l, c;
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 8'hA4)), 0);
            kind = $urandom_range(0, 9);
            send_byte(SYNC, $urandom_range(0, 2));
            if (kind == 0) begin
                l = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
                send_byte(l, 1);
                e_len++;
            end else begin
                l = 8'($urandom_range(1, MAX_LEN));
                s = l;
                send_byte(l, $urandom_range(0, 2));
                for (int i = 0; i < int'(l); i++) begin
                    b = 8'($urandom);
                    s = s + b;
                    send_byte(b, $urandom_range(0, 2));
                    if (kind != 1) exp_q.push_back({(i == int'(l) - 1), b});
                end
                if (kind == 1) begin
                    c = s + 8'($urandom_range(1, 255));
                    e_chk++;
                end else begin
                    c = s;
                    e_good++;
                end
                send_byte(c, 0);
                if (kind != 1) begin
                    wait_rx(exp_q.size(), ok);
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL rand_drain_timeout frame=%0d got n=%0d want %0d",
                                 f, rx_q.size(), exp_q.size());
                    end
                end else begin
                    repeat (2) @(negedge clk);
                end
            end
        end
        rand_ready = 1'b0;
        @(posedge clk); #1 m_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got %0d bytes want %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_byte%0d got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (n_len != e_len || n_chk != e_chk || n_ovr != 0 || n_to != 0 || stab_viol != 0) begin
            errors++;
            $display("FAIL rand_errs got len=%0d chk=%0d ovr=%0d to=%0d stab=%0d want %0d/%0d/0/0/0",
                     n_len, n_chk, n_ovr, n_to, stab_viol, e_len, e_chk);
        end
        checks++;
        if (pkt_count !== base + 16'(e_good)) begin
            errors++;
            $display("FAIL rand_pkt_count got %0d want %0d", pkt_count, base + 16'(e_good));
        end
    endtask

`ifdef RX_TIMEOUT_EN
    task automatic test_timeout();
        int k = 0;
        bit ok;
        clear_mon();
        send_byte(SYNC, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
        while (!to_err && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != TO_CYC) begin
            errors++;
            $display("FAIL timeout_cycles got %0d want %0d", k, TO_CYC);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n_to != 1) begin
            errors++;
            $display("FAIL timeout_pulse got %0d pulses want 1", n_to);
        end
        send_byte(SYNC, 0); send_byte(8'h01, 0); send_byte(8'h7F, 0); send_byte(8'h80, 0);
        wait_rx(1, ok);
        checks++;
        if (!ok || rx_q.size() != 1 || rx_q[0] !== {1'b1, 8'h7F}) begin
            errors++;
            $display("FAIL timeout_recover got n=%0d want one byte 17f", rx_q.size());
        end
    endtask
`endif

    task automatic test_abort();
        logic [15:0] base;
        bit ok;
        // asynchronous reset mid-frame
        clear_mon();
        send_byte(SYNC, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_data, m_last, len_err, chk_err, ovr_err, to_err, rx_en} !== 14'd0 ||
            pkt_count !== 16'd0) begin
            errors++;
            $display("FAIL abort_reset got v=%b d=%h rx_en=%b cnt=%0d want all 0",
                     m_valid, m_data, rx_en, pkt_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_byte(SYNC, 0); send_byte(8'h01, 0); send_byte(8'h7F, 0); send_byte(8'h80, 0);
        wait_rx(1, ok);
        checks++;
        if (!ok || rx_q.size() != 1 || rx_q[0] !== {1'b1, 8'h7F} || pkt_count !== 16'd1) begin
            errors++;
            $display("FAIL abort_rst_result got n=%0d cnt=%0d want one byte 17f cnt=1",
                     rx_q.size(), pkt_count);
        end
        // same sequence with en dropped instead of reset
        clear_mon();
        base = pkt_count;
        send_byte(SYNC, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || rx_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_en_low got v=%b rx_en=%b want 0/0", m_valid, rx_en);
        end
        en = 1'b1;
        @(negedge clk);
        send_byte(SYNC, 0); send_byte(8'h01, 0); send_byte(8'h7F, 0); send_byte(8'h80, 0);
        wait_rx(1, ok);
        checks++;
        if (!ok || rx_q.size() != 1 || rx_q[0] !== {1'b1, 8'h7F} || pkt_count !== base + 16'd1 ||
            (n_len + n_chk + n_ovr + n_to) != 0) begin
            errors++;
            $display("FAIL abort_en_result got n=%0d cnt=%0d errs=%0d want one byte 17f cnt=%0d errs=0",
                     rx_q.size(), pkt_count, n_len + n_chk + n_ovr + n_to, base + 16'd1);
        end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_chk_err();
        test_len_err();
        test_backpressure();
        test_random();
`ifdef RX_TIMEOUT_EN
        test_timeout();
`endif
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop so the run always ends on its own
    initial begin
        #2000000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
